// File: rtl/l2_plru_ctrl.sv
// 4-way tree-PLRU controller for the L2: victim query and update over an external 8x3 LRU array.
// Optional init sweep of the array is compiled in with `define L2_PLRU_INIT_SWEEP_EN.
module l2_plru_ctrl #(
  parameter logic [2:0] INIT_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_touch,
  input  logic [2:0] req_index,
  input  logic [1:0] req_way,
  output logic       resp_valid,
  output logic [1:0] resp_victim,
  output logic [2:0] lru_index,
  output logic [2:0] lru_in,
  output logic       ld_lru,
  input  logic [2:0] lru_rdata,
  output logic       init_busy
);

`ifdef L2_PLRU_INIT_SWEEP_EN
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_LOOKUP = 2'd2} state_t;
  localparam state_t RESET_ST = ST_INIT;
  logic [2:0] sweep_cnt;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd1, ST_LOOKUP = 2'd2} state_t;
  localparam state_t RESET_ST = ST_IDLE;
`endif

  state_t     state;
  logic [2:0] idx_q;
  logic [1:0] way_q;
  logic       touch_q;

  // bit2 picks the pair; bit1 resolves ways 0/1, bit0 resolves ways 2/3
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (b[2]) return b[0] ? 2'd3 : 2'd2;
    else      return b[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    case (w)
      2'd0:    return {2'b11, b[0]};
      2'd1:    return {2'b10, b[0]};
      2'd2:    return {1'b0, b[1], 1'b1};
      default: return {1'b0, b[1], 1'b0};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_ST;
      idx_q   <= '0;
      way_q   <= '0;
      touch_q <= 1'b0;
`ifdef L2_PLRU_INIT_SWEEP_EN
      sweep_cnt <= '0;
`endif
    end else begin
      case (state)
`ifdef L2_PLRU_INIT_SWEEP_EN
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + 3'd1;
          if (sweep_cnt == 3'd7) state <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (req_valid) begin
            idx_q   <= req_index;
            way_q   <= req_way;
            touch_q <= req_touch;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Array read is combinational, so the LOOKUP outputs are decoded from lru_rdata in-cycle
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_victim = '0;
    ld_lru      = 1'b0;
    lru_in      = '0;
    lru_index   = req_index;
    init_busy   = 1'b0;
    case (state)
`ifdef L2_PLRU_INIT_SWEEP_EN
      ST_INIT: begin
        init_busy = 1'b1;
        ld_lru    = ~reset;
        lru_in    = INIT_VAL;
        lru_index = sweep_cnt;
      end
`endif
      ST_IDLE: req_ready = 1'b1;
      ST_LOOKUP: begin
        lru_index   = idx_q;
        resp_valid  = 1'b1;
        resp_victim = plru_victim(lru_rdata);
        if (touch_q) begin
          ld_lru = 1'b1;
          lru_in = plru_touch(lru_rdata, way_q);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_plru_ctrl.sv
// Directed bench for l2_plru_ctrl with a behavioural 8x3 LRU array; covers both L2_PLRU_INIT_SWEEP_EN builds.
module tb_l2_plru_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_touch;
  logic [2:0] req_index;
  logic [1:0] req_way;
  logic       resp_valid;
  logic [1:0] resp_victim;
  logic [2:0] lru_index;
  logic [2:0] lru_in;
  logic       ld_lru;
  logic [2:0] lru_rdata;
  logic       init_busy;

  logic [2:0] mem [8];
  logic       pl_en;
  logic [2:0] pl_idx;
  logic [2:0] pl_val;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_plru_ctrl #(.INIT_VAL(3'b000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_touch(req_touch), .req_index(req_index), .req_way(req_way),
    .resp_valid(resp_valid), .resp_victim(resp_victim), .lru_index(lru_index),
    .lru_in(lru_in), .ld_lru(ld_lru), .lru_rdata(lru_rdata), .init_busy(init_busy)
  );

  // LRU array model: combinational read, write on rising edge; pl_* is a bench-side preload port
  assign lru_rdata = mem[lru_index];
  always @(posedge clk) begin
    if (ld_lru) mem[lru_index] <= lru_in;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  typedef struct {
    logic [2:0] pre;
    logic       touch;
    logic [2:0] idx;
    logic [1:0] way;
    logic [1:0] exp_victim;
    logic [2:0] exp_in;
    logic [2:0] exp_after;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [2:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int unsigned k;
    k = 0;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

`ifdef L2_PLRU_INIT_SWEEP_EN
  // Called right after reset falls at a negedge: expects index 0..7 on consecutive cycles
  task automatic sweep_check(input string name);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk({name, "_ld"}, 32'(ld_lru), 32'd1);
      chk({name, "_idx"}, 32'(lru_index), 32'(i));
      chk({name, "_in"}, 32'(lru_in), 32'd0);
      chk({name, "_busy"}, 32'(init_busy), 32'd1);
      chk({name, "_rdy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    chk({name, "_busy_done"}, 32'(init_busy), 32'd0);
    chk({name, "_rdy_done"}, 32'(req_ready), 32'd1);
  endtask
`endif

  initial begin
    //            pre     t  idx   way   vic   in      after
    vecs[0]  = '{3'b000, 1, 3'd3, 2'd0, 2'd0, 3'b110, 3'b110};
    vecs[1]  = '{3'b110, 0, 3'd3, 2'd0, 2'd2, 3'b000, 3'b110};
    vecs[2]  = '{3'b110, 1, 3'd5, 2'd3, 2'd2, 3'b010, 3'b010};
    vecs[3]  = '{3'b010, 0, 3'd5, 2'd0, 2'd1, 3'b000, 3'b010}; // 010: bit2=0, bit1=1 -> way1
    vecs[4]  = '{3'b101, 0, 3'd1, 2'd2, 2'd3, 3'b000, 3'b101};
    vecs[5]  = '{3'b000, 1, 3'd0, 2'd1, 2'd0, 3'b100, 3'b100};
    vecs[6]  = '{3'b100, 1, 3'd6, 2'd2, 2'd2, 3'b001, 3'b001};
    vecs[7]  = '{3'b001, 0, 3'd6, 2'd1, 2'd0, 3'b000, 3'b001};
    vecs[8]  = '{3'b011, 1, 3'd7, 2'd0, 2'd1, 3'b111, 3'b111};
    vecs[9]  = '{3'b111, 1, 3'd2, 2'd3, 2'd3, 3'b010, 3'b010};
    vecs[10] = '{3'b000, 1, 3'd4, 2'd2, 2'd0, 3'b001, 3'b001};
    vecs[11] = '{3'b001, 1, 3'd4, 2'd1, 2'd0, 3'b101, 3'b101};

    reset = 1'b1; req_valid = 1'b0; req_touch = 1'b0; req_index = 3'd2; req_way = 2'd0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;

    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_victim", 32'(resp_victim), 32'd0);
    chk("rst_ld_lru", 32'(ld_lru), 32'd0);
`ifdef L2_PLRU_INIT_SWEEP_EN
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    sweep_check("sweep");
`else
    chk("rst_init_busy", 32'(init_busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_ld_lru", 32'(ld_lru), 32'd0);
    chk("idle_lru_in", 32'(lru_in), 32'd0);
    chk("idle_lru_index", 32'(lru_index), 32'd2);
    chk("idle_init_busy", 32'(init_busy), 32'd0);
`endif

    // Table-driven single requests
    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].idx, vecs[i].pre);
      req_valid = 1'b1; req_touch = vecs[i].touch; req_index = vecs[i].idx; req_way = vecs[i].way;
      wait_ready("vec");
      #1;
      chk("vec_idle_index", 32'(lru_index), 32'(vecs[i].idx));
      chk("vec_idle_ld", 32'(ld_lru), 32'd0);
      @(negedge clk);
      req_valid = 1'b0; req_index = 3'd0;
      chk("vec_resp_valid", 32'(resp_valid), 32'd1);
      chk("vec_victim", 32'(resp_victim), 32'(vecs[i].exp_victim));
      chk("vec_lookup_index", 32'(lru_index), 32'(vecs[i].idx));
      chk("vec_ld_lru", 32'(ld_lru), 32'(vecs[i].touch));
      if (vecs[i].touch) chk("vec_lru_in", 32'(lru_in), 32'(vecs[i].exp_in));
      chk("vec_ready_lookup", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("vec_pulse_end", 32'(resp_valid), 32'd0);
      chk("vec_array_after", 32'(mem[vecs[i].idx]), 32'(vecs[i].exp_after));
    end

    // req_valid held high: touch way0 on set 3, then an immediate query must see 110 -> victim 2
    preload(3'd3, 3'b000);
    req_valid = 1'b1; req_touch = 1'b1; req_index = 3'd3; req_way = 2'd0;
    wait_ready("b2b");
    @(negedge clk);
    chk("b2b_resp1", 32'(resp_valid), 32'd1);
    chk("b2b_victim1", 32'(resp_victim), 32'd0);
    chk("b2b_lru_in1", 32'(lru_in), 32'b110);
    req_touch = 1'b0;
    @(negedge clk);
    chk("b2b_gap_resp", 32'(resp_valid), 32'd0);
    chk("b2b_gap_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b_resp2", 32'(resp_valid), 32'd1);
    chk("b2b_victim2", 32'(resp_victim), 32'd2);
    chk("b2b_ld2", 32'(ld_lru), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end", 32'(resp_valid), 32'd0);

    // Continuous req_valid: responses alternate 1,0,1,0...
    req_valid = 1'b1; req_touch = 1'b0; req_index = 3'd1;
    wait_ready("tput");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("tput_pulse", 32'(resp_valid), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset in LOOKUP: no pulse, no write
    preload(3'd6, 3'b011);
    req_valid = 1'b1; req_touch = 1'b1; req_index = 3'd6; req_way = 2'd3;
    wait_ready("abort");
    @(negedge clk);
    chk("abort_in_lookup", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("abort_resp", 32'(resp_valid), 32'd0);
    chk("abort_ld", 32'(ld_lru), 32'd0);
    chk("abort_victim", 32'(resp_victim), 32'd0);
    @(negedge clk);
    chk("abort_array", 32'(mem[6]), 32'b011);
    reset = 1'b0;
`ifdef L2_PLRU_INIT_SWEEP_EN
    sweep_check("abort_sweep");

    // Reset at sweep index 4 restarts from 0 and every set ends at INIT_VAL
    for (int s = 0; s < 8; s++) preload(3'(s), 3'b111);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_idx4", 32'(lru_index), 32'd4);
    reset = 1'b1;
    #1;
    chk("mid_rst_ld", 32'(ld_lru), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sweep_check("restart");
    for (int s = 0; s < 8; s++) chk("restart_set", 32'(mem[s]), 32'd0);
`else
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_init_busy", 32'(init_busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
